// File: rtl/l2_arbiter_rr_pkg.sv
// lc3b_types: shared LC-3b widths plus the L2 arbiter's state, source and
// request types.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic       {ARB_SRC_I, ARB_SRC_D}         arb_src_t;

  // One requester's view of an L2 transaction
  typedef struct packed {
    lc3b_word       addr;
    lc3b_cache_line wdata;
    logic           read;
    logic           write;
  } arb_req_t;

endpackage

// File: rtl/l2_arbiter_rr_pick.sv
// rr_pick: combinational two-input selector for the L2 arbiter.
//   req_i, req_d : requester active flags
//   last         : source granted most recently
//   grant        : selected source (meaningful only when valid)
//   valid        : at least one requester is active
// ARB_ROUND_ROBIN_EN defined   -> ties go to the source not granted last.
// ARB_ROUND_ROBIN_EN undefined -> ties always go to the icache.
module rr_pick
  import lc3b_types::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  arb_src_t last,
  output arb_src_t grant,
  output logic     valid
);

  assign valid = req_i | req_d;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = ARB_SRC_I;
    if (req_i && req_d) grant = (last == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
    else if (req_d)     grant = ARB_SRC_D;
  end
`else
  logic unused_last;
  assign unused_last = (last == ARB_SRC_D);

  always_comb begin
    grant = ARB_SRC_I;
    if (!req_i && req_d) grant = ARB_SRC_D;
  end
`endif

endmodule

// File: rtl/l2_arbiter_rr.sv
// l2_arbiter_rr: shares the single L2 port between the split L1 caches.
// The winning request is latched and drives the L2 from registers until
// l2_mem_resp; the winner then gets a registered one-cycle mem_resp with
// its rdata. The FSM passes through IDLE after every response, so grants
// are separated by at least one idle cycle.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   icache_* / dcache_*               : L1 request/response ports
//   l2_address/wdata/read/write       : latched request to the L2
//   l2_rdata, l2_mem_resp             : L2 response
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break (else fixed icache
// priority with no last_grant state).
module l2_arbiter_rr
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  lc3b_word       icache_address,
  input  logic           icache_read,
  input  logic           icache_write,
  input  lc3b_cache_line icache_wdata,
  output lc3b_cache_line icache_rdata,
  output logic           icache_mem_resp,
  input  lc3b_word       dcache_address,
  input  logic           dcache_read,
  input  logic           dcache_write,
  input  lc3b_cache_line dcache_wdata,
  output lc3b_cache_line dcache_rdata,
  output logic           dcache_mem_resp,
  output lc3b_word       l2_address,
  output lc3b_cache_line l2_wdata,
  output logic           l2_read,
  output logic           l2_write,
  input  lc3b_cache_line l2_rdata,
  input  logic           l2_mem_resp
);

  arb_state_t state;
  arb_src_t   winner;
  arb_src_t   last_grant;
  arb_src_t   pick;
  logic       pick_vld;
  arb_req_t   req_i, req_d, req_sel;

  assign req_i   = '{addr: icache_address, wdata: icache_wdata,
                     read: icache_read,    write: icache_write};
  assign req_d   = '{addr: dcache_address, wdata: dcache_wdata,
                     read: dcache_read,    write: dcache_write};
  assign req_sel = (pick == ARB_SRC_D) ? req_d : req_i;

  rr_pick u_pick (
    .req_i (icache_read | icache_write),
    .req_d (dcache_read | dcache_write),
    .last  (last_grant),
    .grant (pick),
    .valid (pick_vld)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to dcache so the first tie goes to the icache
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          last_grant <= ARB_SRC_D;
    else if (state == ARB_IDLE && pick_vld) last_grant <= pick;
  end
`else
  assign last_grant = ARB_SRC_D;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ARB_IDLE;
      winner          <= ARB_SRC_I;
      l2_address      <= '0;
      l2_wdata        <= '0;
      l2_read         <= 1'b0;
      l2_write        <= 1'b0;
      icache_rdata    <= '0;
      dcache_rdata    <= '0;
      icache_mem_resp <= 1'b0;
      dcache_mem_resp <= 1'b0;
    end else begin
      icache_mem_resp <= 1'b0;
      dcache_mem_resp <= 1'b0;
      case (state)
        ARB_IDLE: if (pick_vld) begin
          winner     <= pick;
          l2_address <= req_sel.addr;
          l2_wdata   <= req_sel.wdata;
          // write wins when a requester raises both strobes
          l2_write   <= req_sel.write;
          l2_read    <= req_sel.read & ~req_sel.write;
          state      <= ARB_BUSY;
        end
        ARB_BUSY: if (l2_mem_resp) begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
          if (winner == ARB_SRC_I) begin
            icache_rdata    <= l2_rdata;
            icache_mem_resp <= 1'b1;
          end else begin
            dcache_rdata    <= l2_rdata;
            dcache_mem_resp <= 1'b1;
          end
          state <= ARB_RESP;
        end
        // requester still holds its request here; never regrant from RESP
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Randomized scoreboard bench for l2_arbiter_rr. A transaction-level model
// decides each grant from the requesters' inputs and queues the expected L2
// request and L1 response; independent monitors compare when the DUT shows
// an L2 strobe or a mem_resp.
module tb_l2_arbiter_rr;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  icache_address, dcache_address, l2_address;
  logic         icache_read, icache_write, dcache_read, dcache_write;
  logic [127:0] icache_wdata, dcache_wdata, icache_rdata, dcache_rdata;
  logic         icache_mem_resp, dcache_mem_resp;
  logic [127:0] l2_wdata, l2_rdata;
  logic         l2_read, l2_write, l2_mem_resp;

  always #5 clk = ~clk;

  l2_arbiter_rr dut (
    .clk(clk), .reset_n(reset_n),
    .icache_address(icache_address), .icache_read(icache_read),
    .icache_write(icache_write), .icache_wdata(icache_wdata),
    .icache_rdata(icache_rdata), .icache_mem_resp(icache_mem_resp),
    .dcache_address(dcache_address), .dcache_read(dcache_read),
    .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_mem_resp(dcache_mem_resp),
    .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_read(l2_read),
    .l2_write(l2_write), .l2_rdata(l2_rdata), .l2_mem_resp(l2_mem_resp)
  );

  typedef struct { logic [15:0] addr; logic [127:0] wdata; logic rd; logic wr; } l2_exp_t;
  typedef struct { int src; logic [127:0] data; } rsp_exp_t;

  int checks = 0;
  int errors = 0;
  l2_exp_t  exp_l2[$];
  rsp_exp_t exp_rsp[$];
  int       grant_log[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- L2 memory model ----------------
  int l2_fix_delay = -1;  // -1: random latency and data
  int l2_wait = -1;
  bit l2_done = 0;
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_mem_resp = 1'b0; l2_rdata = '0; l2_wait = -1; l2_done = 0;
    end else begin
      l2_mem_resp = 1'b0;
      if ((l2_read || l2_write) && !l2_done) begin
        if (l2_wait < 0) l2_wait = (l2_fix_delay >= 0) ? l2_fix_delay : int'($urandom_range(4, 0));
        if (l2_wait == 0) begin
          l2_mem_resp = 1'b1;
          l2_rdata    = (l2_fix_delay >= 0) ? {16{8'hA5}} : rnd128();
          l2_done     = 1;
          l2_wait     = -1;
        end else l2_wait--;
      end
      if (!(l2_read || l2_write)) l2_done = 0;
    end
  end

  // ---------------- reference model ----------------
  // Port is free, in flight, or cooling down for one cycle after a response
  // (the mandatory turnaround). A free port grants on any active request.
  int m_phase = 0;  // 0 free, 1 in flight, 2 cooldown
  int m_win   = 0;  // 0 icache, 1 dcache
  int m_last  = 1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_last = 1;
      exp_l2.delete(); exp_rsp.delete();
    end else if (m_phase == 0) begin
      bit ia, da;
      ia = icache_read | icache_write;
      da = dcache_read | dcache_write;
      if (ia || da) begin
        l2_exp_t e;
        if (ia && da) begin
`ifdef ARB_ROUND_ROBIN_EN
          m_win = 1 - m_last;
`else
          m_win = 0;
`endif
        end else m_win = ia ? 0 : 1;
        m_last = m_win;
        if (m_win == 0) e = '{icache_address, icache_wdata, icache_read & ~icache_write, icache_write};
        else            e = '{dcache_address, dcache_wdata, dcache_read & ~dcache_write, dcache_write};
        exp_l2.push_back(e);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (l2_mem_resp) begin
        exp_rsp.push_back('{m_win, l2_rdata});
        m_phase = 2;
      end
    end else m_phase = 0;
  end

  // ---------------- monitors ----------------
  l2_exp_t      cur;
  bit           have_cur = 0, prev_strobe = 0;
  logic [127:0] exp_ird = '0, exp_drd = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      have_cur = 0; prev_strobe = 0; exp_ird = '0; exp_drd = '0;
    end else begin
      if ((l2_read || l2_write) && !prev_strobe) begin
        if (exp_l2.size() == 0) begin
          checks++; errors++;
          $display("FAIL l2_unexpected act=strobe exp=none t=%0t", $time);
          have_cur = 0;
        end else begin
          cur = exp_l2.pop_front();
          have_cur = 1;
        end
      end
      if ((l2_read || l2_write) && have_cur)
        chk("l2_req", {l2_address, l2_wdata, l2_read, l2_write},
                      {cur.addr, cur.wdata, cur.rd, cur.wr});
      prev_strobe = l2_read || l2_write;

      if (icache_mem_resp || dcache_mem_resp) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected act=%b%b exp=none t=%0t",
                   icache_mem_resp, dcache_mem_resp, $time);
        end else begin
          rsp_exp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_src", {icache_mem_resp, dcache_mem_resp}, (r.src == 0) ? 2'b10 : 2'b01);
          if (r.src == 0) exp_ird = r.data; else exp_drd = r.data;
          grant_log.push_back(r.src);
        end
      end
      chk("icache_rdata", icache_rdata, exp_ird);
      chk("dcache_rdata", dcache_rdata, exp_drd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int src, input logic [15:0] a, input logic [127:0] d,
                       input logic rd, input logic wr);
    if (src == 0) begin
      icache_address = a; icache_wdata = d; icache_read = rd; icache_write = wr;
    end else begin
      dcache_address = a; dcache_wdata = d; dcache_read = rd; dcache_write = wr;
    end
  endtask

  // Issue n random requests; hold each until its response, wiggling address
  // and data while waiting.
  task automatic requester(input int src, input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      int gap, op, w;
      logic rd, wr;
      gap = int'($urandom_range(gap_max, 0));
      op  = int'($urandom_range(2, 0));
      rd  = (op != 1);
      wr  = (op != 0);
      repeat (gap) @(negedge clk);
      drive(src, 16'($urandom), rnd128(), rd, wr);
      w = 0;
      do begin
        @(negedge clk); w++;
        if ($urandom_range(3, 0) == 0) drive(src, 16'($urandom), rnd128(), rd, wr);
      end while (!((src == 0) ? icache_mem_resp : dcache_mem_resp) && w < 300);
      chk("req_timeout", (w < 300), 1'b1);
      drive(src, '0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {l2_address, l2_wdata, l2_read, l2_write, icache_mem_resp,
               dcache_mem_resp, icache_rdata, dcache_rdata}, '0);
  endtask

  initial begin
    int base, lat, hi, g;
    drive(0, '0, '0, 1'b0, 1'b0);
    drive(1, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_state");
    reset_n = 1'b1;
    repeat (10) begin @(negedge clk); chk_quiet("idle_quiet"); end

    // both caches read continuously: 4 grants
    base = grant_log.size();
    drive(0, 16'h1000, '0, 1'b1, 1'b0);
    drive(1, 16'h2000, '0, 1'b1, 1'b0);
    g = 0;
    while (grant_log.size() < base + 4 && g < 200) begin @(negedge clk); g++; end
    drive(0, '0, '0, 1'b0, 1'b0);
    drive(1, '0, '0, 1'b0, 1'b0);
    chk("tie_timeout", (g < 200), 1'b1);
    for (int k = 0; k < 4 && base + k < grant_log.size(); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_grant", grant_log[base+k], k % 2);
`else
      chk("tie_grant", grant_log[base+k], 0);
`endif
    end
    repeat (5) @(negedge clk);

    // single icache read, L2 latency 3
    l2_fix_delay = 3;
    drive(0, 16'h1230, '0, 1'b1, 1'b0);
    lat = 0; hi = 0;
    do begin @(negedge clk); lat++; if (l2_read) hi++; end
    while (!icache_mem_resp && lat < 50);
    drive(0, '0, '0, 1'b0, 1'b0);
    chk("single_latency", lat, 5);
    chk("single_rd_cycles", hi, 4);
    chk("single_rdata", icache_rdata, {16{8'hA5}});
    repeat (3) @(negedge clk);

    // dcache write arrives while icache is busy
    drive(0, 16'h1230, '0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1, 16'h4000, {16{8'h0F}}, 1'b0, 1'b1);
    g = 0;
    do begin @(negedge clk); g++; end while (!icache_mem_resp && g < 50);
    drive(0, '0, '0, 1'b0, 1'b0);
    g = 0;
    do begin @(negedge clk); g++; end while (!l2_write && g < 50);
    chk("wr_gap_after_resp", g, 2);
    chk("wr_strobe", {l2_address, l2_wdata, l2_write, l2_read},
                     {16'h4000, {16{8'h0F}}, 1'b1, 1'b0});
    drive(1, 16'h5555, rnd128(), 1'b0, 1'b1);
    @(negedge clk);
    chk("addr_held", l2_address, 16'h4000);
    g = 0;
    while (!dcache_mem_resp && g < 50) begin @(negedge clk); g++; end
    drive(1, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // reset during BUSY
    l2_fix_delay = 20;
    drive(0, 16'h3333, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_reset", l2_read, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_quiet("async_reset");
    drive(0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    l2_fix_delay = -1;
    repeat (4) @(negedge clk);
    requester(0, 1, 0);

    // random contention
    fork
      requester(0, 15, 3);
      requester(1, 15, 3);
    join
    repeat (10) @(negedge clk);
    chk("drain_l2", exp_l2.size(), 0);
    chk("drain_rsp", exp_rsp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
